c3lib_ckmux4_sel_ctrl: RTL and testbench

Glitch-safe select sequencer that drives the `s0`/`s1` selects of a 4-to-1 clock mux and the enable of the clock gate placed after the mux. A requester asks for a new clock source with a valid/ready handshake. The block then gates the muxed clock off, waits, changes the select, waits again, and re-enables the clock. It runs on one always-on reference clock and sits beside the mux in the clocking subsystem.

---
 rtl/c3lib_ckmux4_sel_ctrl.sv | 135 +++++++++++++
 tb/tb_c3lib_ckmux4_sel_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/c3lib_ckmux4_sel_ctrl.sv
// Select sequencer for a 4:1 clock mux: gate the muxed clock, change {s1,s0}, settle, then re-enable.
// Every output is registered, so the mux and the gate never see a combinational glitch from this block.
module c3lib_ckmux4_sel_ctrl #(
    parameter int         GATE_WAIT   = 4,
    parameter int         SETTLE_WAIT = 4,
    parameter logic [1:0] RST_SEL     = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_vld,
    input  logic [1:0] req_sel,
    output logic       req_rdy,
    output logic       s0,
    output logic       s1,
    output logic       ck_en,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state
);

    // Handshake: a request transfers on a rising clk edge where req_vld && req_rdy;
    // req_rdy is a registered IDLE decode and never looks at req_vld.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [7:0] GATE_LD   = 8'(GATE_WAIT - 1);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_WAIT - 1);

    state_t     r_state, w_state;
    logic [7:0] r_cnt, w_cnt;
    logic [1:0] r_sel, w_sel;
    logic [1:0] r_pend_sel, w_pend_sel;
    logic       r_ck_en, w_ck_en;
    logic       r_busy, w_busy;
    logic       r_rdy, w_rdy;
    logic       r_done, w_done;
    logic       r_startup, w_startup;
    logic       w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SETTLE;
            r_cnt      <= SETTLE_LD;
            r_sel      <= RST_SEL;
            r_pend_sel <= RST_SEL;
            r_ck_en    <= 1'b0;
            r_busy     <= 1'b1;
            r_rdy      <= 1'b0;
            r_done     <= 1'b0;
            r_startup  <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_sel      <= w_sel;
            r_pend_sel <= w_pend_sel;
            r_ck_en    <= w_ck_en;
            r_busy     <= w_busy;
            r_rdy      <= w_rdy;
            r_done     <= w_done;
            r_startup  <= w_startup;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_sel      = r_sel;
        w_pend_sel = r_pend_sel;
        w_ck_en    = r_ck_en;
        w_busy     = r_busy;
        w_rdy      = r_rdy;
        w_done     = 1'b0;
        w_startup  = r_startup;
        w_accept   = req_vld & r_rdy;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (req_sel == r_sel) begin
                        w_done = 1'b1;
                    end else begin
                        w_pend_sel = req_sel;
                        w_state    = GATE;
                        w_ck_en    = 1'b0;
                        w_busy     = 1'b1;
                        w_rdy      = 1'b0;
                        w_cnt      = GATE_LD;
                    end
                end
            end
            GATE: begin
                // The select moves only here, with the clock gate already closed.
                if (r_cnt == 8'd0) begin
                    w_state = SETTLE;
                    w_sel   = r_pend_sel;
                    w_cnt   = SETTLE_LD;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            SETTLE: begin
                if (r_cnt == 8'd0) begin
                    w_state   = IDLE;
                    w_ck_en   = 1'b1;
                    w_busy    = 1'b0;
                    w_rdy     = 1'b1;
                    w_done    = ~r_startup;
                    w_startup = 1'b0;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state = SETTLE;
                w_cnt   = SETTLE_LD;
                w_ck_en = 1'b0;
                w_busy  = 1'b1;
                w_rdy   = 1'b0;
            end
        endcase
    end

    assign req_rdy   = r_rdy;
    assign s0        = r_sel[0];
    assign s1        = r_sel[1];
    assign ck_en     = r_ck_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_c3lib_ckmux4_sel_ctrl.sv
// Bench for c3lib_ckmux4_sel_ctrl: directed steps then random requests against a timeline model
// that predicts each output from the edge number at which a request was accepted.
module tb_c3lib_ckmux4_sel_ctrl;
  localparam int GW = 4;
  localparam int SW = 3;
  localparam logic [1:0] RSEL = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_vld = 1'b0;
  logic [1:0] req_sel = 2'b00;
  logic       req_rdy, s0, s1, ck_en, busy, done;
  logic [1:0] dbg_state;

  c3lib_ckmux4_sel_ctrl #(.GATE_WAIT(GW), .SETTLE_WAIT(SW), .RST_SEL(RSEL)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_sel(req_sel), .req_rdy(req_rdy),
    .s0(s0), .s1(s1), .ck_en(ck_en), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // timeline model: edge counter plus the edges at which the current switch moves the select and ends
  int         e = 0;
  logic [1:0] m_old = RSEL, m_new = RSEL;
  int         m_sel_edge = 0, m_end = SW, m_done_edge = -1;
  logic       m_rdy = 1'b0;
  int         n_acc = 0, n_done = 0;
  logic [1:0] prev_sel = RSEL;
  logic       prev_ck = 1'b0;
  logic       acc_last = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    logic       acc;
    logic       idle;
    logic [1:0] exp_sel;
    acc = req_vld && m_rdy && !rst;
    @(posedge clk);
    e++;
    if (rst) begin
      m_old = RSEL; m_new = RSEL; m_sel_edge = 0; m_end = e + SW; m_done_edge = -1;
    end else if (acc) begin
      n_acc++;
      if (req_sel == m_new) begin
        m_done_edge = e;
      end else begin
        m_old = m_new; m_new = req_sel;
        m_sel_edge = e + GW; m_end = e + GW + SW; m_done_edge = m_end;
      end
    end
    acc_last = acc;
    #1;
    idle = (e >= m_end);
    exp_sel = (e >= m_sel_edge) ? m_new : m_old;
    m_rdy = idle;
    chk(tag, {2'b00, req_rdy, busy, ck_en, done, s1, s0},
        {2'b00, idle, ~idle, idle, (e == m_done_edge), exp_sel});
    if (({s1, s0} != prev_sel) && !rst)
      chk("sel_gated", {6'd0, prev_ck, ck_en}, 8'd0);
    if (done === 1'b1) n_done++;
    prev_sel = {s1, s0};
    prev_ck = ck_en;
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    // reset release and startup
    ticks("reset", 3);
    chk("rst_sel", {6'd0, s1, s0}, 8'h00);
    chk("rst_ck_en", {7'd0, ck_en}, 8'h00);
    rst = 1'b0;
    ticks("startup", 2);
    chk("startup_early_ck_en", {7'd0, ck_en}, 8'h00);
    tick("startup");
    chk("startup_ck_en", {7'd0, ck_en}, 8'h01);
    chk("startup_rdy", {7'd0, req_rdy}, 8'h01);
    chk("startup_no_done", {7'd0, done}, 8'h00);
    ticks("idle", 2);

    // switch 00 -> 10
    req_vld = 1'b1; req_sel = 2'b10;
    tick("sw10_k");
    req_vld = 1'b0;
    chk("sw10_ck_off", {7'd0, ck_en}, 8'h00);
    ticks("sw10_gate", 3);
    chk("sw10_sel_hold", {6'd0, s1, s0}, 8'h00);
    tick("sw10_k4");
    chk("sw10_sel_new", {6'd0, s1, s0}, 8'h02);
    ticks("sw10_settle", 3);
    chk("sw10_ck_on", {7'd0, ck_en}, 8'h01);
    chk("sw10_done", {7'd0, done}, 8'h01);
    tick("sw10_after");
    chk("sw10_done_1cyc", {7'd0, done}, 8'h00);

    // same select 10 -> 10, back to back
    req_vld = 1'b1; req_sel = 2'b10;
    tick("same_k");
    chk("same_done", {7'd0, done}, 8'h01);
    chk("same_rdy", {7'd0, req_rdy}, 8'h01);
    tick("same_k2");
    req_vld = 1'b0;
    chk("same_ck_en", {7'd0, ck_en}, 8'h01);
    tick("same_after");
    chk("same_done_end", {7'd0, done}, 8'h00);

    // held request for 11 while 10 -> 01 runs
    req_vld = 1'b1; req_sel = 2'b01;
    tick("held_k");
    req_sel = 2'b11;
    ticks("held_run", 7);
    chk("held_first_sel", {6'd0, s1, s0}, 8'h01);
    chk("held_first_done", {7'd0, done}, 8'h01);
    tick("held_accept");
    req_vld = 1'b0;
    chk("held_accept_ck_off", {7'd0, ck_en}, 8'h00);
    ticks("held_gate", 3);
    chk("held_sel_hold", {6'd0, s1, s0}, 8'h01);
    tick("held_k4");
    chk("held_sel_11", {6'd0, s1, s0}, 8'h03);
    ticks("held_settle", 3);

    // back to 00, then reset in the middle of the SETTLE of 00 -> 11
    req_vld = 1'b1; req_sel = 2'b00;
    tick("to00");
    req_vld = 1'b0;
    ticks("to00_run", 7);
    req_vld = 1'b1; req_sel = 2'b11;
    tick("mid_k");
    req_vld = 1'b0;
    ticks("mid_run", 5);
    chk("mid_sel_11", {6'd0, s1, s0}, 8'h03);
    rst = 1'b1;
    #1;
    chk("async_sel", {6'd0, s1, s0}, 8'h00);
    chk("async_ck_en", {7'd0, ck_en}, 8'h00);
    chk("async_done", {7'd0, done}, 8'h00);
    prev_sel = {s1, s0};
    ticks("mid_reset", 2);
    rst = 1'b0;
    ticks("restart", 2);
    chk("restart_early_ck_en", {7'd0, ck_en}, 8'h00);
    tick("restart");
    chk("restart_ck_en", {7'd0, ck_en}, 8'h01);
    chk("restart_no_done", {7'd0, done}, 8'h00);

    // random requests with valid held until accepted
    n_acc = 0; n_done = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!(req_vld && !acc_last)) begin
        req_vld = ($urandom_range(0, 2) == 0);
        req_sel = 2'($urandom_range(0, 3));
      end
      tick("random");
    end
    req_vld = 1'b0;
    ticks("drain", GW + SW + 2);
    chk("done_per_accept", 8'(n_done), 8'(n_acc));
    chk("done_count_nonzero", {7'd0, (n_acc > 100)}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
